// File: rtl/ks_adder_pkg.sv
// ks_adder_pkg: shared types and helpers for the pipelined Kogge-Stone adder.
// Contents:
//   ks_pg_t     - one prefix-tree node: group propagate p, group generate g
//   KS_COUT_EN  - 1 when KS_ADDER_COUT_EN is defined (the MSB carry is kept)
//   ks_levels() - number of prefix levels for a given width, clog2(w)
//   ks_span()   - distance between combined nodes at a level, 2^level
//   ks_black()  - black-cell combine of a high node with a lower node
package ks_adder_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } ks_pg_t;

`ifdef KS_ADDER_COUT_EN
    localparam bit KS_COUT_EN = 1'b1;
`else
    localparam bit KS_COUT_EN = 1'b0;
`endif

    function automatic int ks_levels(input int w);
        return (w > 1) ? $clog2(w) : 0;
    endfunction

    function automatic int ks_span(input int level);
        return 1 << level;
    endfunction

    function automatic ks_pg_t ks_black(input ks_pg_t hi, input ks_pg_t lo);
        ks_pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ks_prefix_tree.sv
// ks_prefix_tree: combinational Kogge-Stone prefix network.
// Parameter W : number of bit columns (>= 1).
// Ports:
//   p   [W-1:0] in  - bit propagate
//   g   [W-1:0] in  - bit generate (bit 0 already carries the carry-in)
//   grp [W-1:0] out - group generate G[i:0] for every column i
module ks_prefix_tree import ks_adder_pkg::*; #(
    parameter int W = 16
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] g,
    output logic [W-1:0] grp
);

    localparam int L = ks_levels(W);

    ks_pg_t node [L+1][W];

    for (genvar i = 0; i < W; i++) begin : g_io
        assign node[0][i] = '{p: p[i], g: g[i]};
        assign grp[i]     = node[L][i].g;
    end

    // Columns whose reach already covers bit 0 are complete and pass through.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        for (genvar i = 0; i < W; i++) begin : g_col
            if (i >= ks_span(l)) begin : g_blk
                assign node[l+1][i] = ks_black(node[l][i], node[l][i-ks_span(l)]);
            end else begin : g_pass
                assign node[l+1][i] = node[l][i];
            end
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: two-stage pipelined Kogge-Stone adder with valid/ready handshake.
// Parameter W : operand width (>= 2).
// Ports:
//   clk       in  - rising-edge clock
//   rst_n     in  - asynchronous active-low reset
//   in_valid  in  - a, b, cin valid
//   in_ready  out - operands accepted this cycle (combinational from out_ready)
//   a, b      in  - addends (CSA sum and pre-shifted carry vectors)
//   cin       in  - carry-in
//   out_valid out - sum valid
//   out_ready in  - consumer takes sum this cycle
//   sum       out - (a + b + cin) mod 2^W
//   cout      out - carry out of the MSB, only when KS_ADDER_COUT_EN is defined
module ks_adder_pipe import ks_adder_pkg::*; #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum
`ifdef KS_ADDER_COUT_EN
    ,
    output logic         cout
`endif
);

    // Without cout the MSB group generate is never needed, so the whole
    // column is dropped from the generate register and the tree.
    localparam int GW = KS_COUT_EN ? W : W - 1;

    logic          s1_valid, s2_valid;
    logic          s1_load, s2_load;
    logic          s1_cin, s2_cin;
    logic [W-1:0]  s1_p, s2_p;
    logic [GW-1:0] in_g, s1_g, tree_grp, s2_grp;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    // Folding cin into bit 0 makes every tree output the true carry into bit i+1.
    always_comb begin
        in_g    = a[GW-1:0] & b[GW-1:0];
        in_g[0] = in_g[0] | ((a[0] ^ b[0]) & cin);
    end

    ks_prefix_tree #(.W(GW)) u_tree (
        .p   (s1_p[GW-1:0]),
        .g   (s1_g),
        .grp (tree_grp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_grp   <= '0;
            s2_cin   <= 1'b0;
        end else begin
            if (s1_load) s1_valid <= in_valid;
            if (s1_load && in_valid) begin
                s1_p   <= a ^ b;
                s1_g   <= in_g;
                s1_cin <= cin;
            end
            if (s2_load) s2_valid <= s1_valid;
            if (s2_load && s1_valid) begin
                s2_p   <= s1_p;
                s2_grp <= tree_grp;
                s2_cin <= s1_cin;
            end
        end
    end

    assign sum = s2_p ^ {s2_grp[W-2:0], s2_cin};

`ifdef KS_ADDER_COUT_EN
    assign cout = s2_grp[W-1];
`endif

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(sum));

    a_ready_when_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(s1_valid && s2_valid) |-> in_ready);

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: randomized and directed checks of ks_adder_pipe at W=16 and W=13
// against an arithmetic scoreboard; honours KS_ADDER_COUT_EN.
module tb_ks_adder_pipe;

    localparam int N_RAND = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vin [2];
    logic        rdy [2];
    logic        cin [2];
    logic        ov  [2];
    logic        ordy[2];
    logic        co  [2];
    logic [15:0] a   [2];
    logic [15:0] b   [2];
    logic [15:0] s   [2];
    logic [12:0] s13;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned q0[$];
    int unsigned q1[$];
    logic        held  [2];
    logic [15:0] held_s[2];

    always #5 clk = ~clk;

    ks_adder_pipe #(.W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(rdy[0]),
        .a(a[0]), .b(b[0]), .cin(cin[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .sum(s[0])
`ifdef KS_ADDER_COUT_EN
        , .cout(co[0])
`endif
    );

    ks_adder_pipe #(.W(13)) u13 (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(rdy[1]),
        .a(a[1][12:0]), .b(b[1][12:0]), .cin(cin[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .sum(s13)
`ifdef KS_ADDER_COUT_EN
        , .cout(co[1])
`endif
    );

    assign s[1] = {3'b000, s13};
`ifndef KS_ADDER_COUT_EN
    assign co[0] = 1'b0;
    assign co[1] = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: accepted operands queue their exact sum; drains pop in order.
    // Occupancy equals the queue length, so in_ready must be low exactly when
    // two results are in flight and the consumer is stalling.
    task automatic mon(input int k);
        int          w = k ? 13 : 16;
        int unsigned m = (1 << w) - 1;
        int unsigned e;
        int          sz = k ? q1.size() : q0.size();
        chk(k ? "in_ready13" : "in_ready16", 32'(rdy[k]), 32'(!(sz == 2 && !ordy[k])));
        if (sz == 0) chk("no_spurious_valid", 32'(ov[k]), 0);
        if (held[k]) begin
            chk("stall_valid", 32'(ov[k]), 1);
            chk("stall_sum", 32'(s[k]), 32'(held_s[k]));
        end
        if (ov[k] && ordy[k] && sz > 0) begin
            e = k ? q1.pop_front() : q0.pop_front();
            chk(k ? "sum13" : "sum16", 32'(s[k]), e & m);
`ifdef KS_ADDER_COUT_EN
            chk(k ? "cout13" : "cout16", 32'(co[k]), (e >> w) & 1);
`endif
        end
        held[k]   = ov[k] && !ordy[k];
        held_s[k] = s[k];
        if (vin[k] && rdy[k]) begin
            e = (32'(a[k]) & m) + (32'(b[k]) & m) + 32'(cin[k]);
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            held[0] = 1'b0;
            held[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) mon(k);
        end
    end

    task automatic op(input logic [15:0] aa, input logic [15:0] bb, input logic cc,
                      input logic [15:0] es, input logic ec);
        @(posedge clk); #1;
        vin[0] = 1'b1; a[0] = aa; b[0] = bb; cin[0] = cc; ordy[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        @(negedge clk);
        chk("lat1_valid", 32'(ov[0]), 0);
        @(negedge clk);
        chk("lat2_valid", 32'(ov[0]), 1);
        chk("op_sum", 32'(s[0]), 32'(es));
`ifdef KS_ADDER_COUT_EN
        chk("op_cout", 32'(co[0]), 32'(ec));
`else
        if (ec === 1'bx) $display("note: unknown carry expectation");
`endif
    endtask

    initial begin
        int first, last, cnt, sent1;
        int sent[2];
        logic took[2];
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0; a[k] = '0; b[k] = '0; cin[k] = 1'b0; ordy[k] = 1'b1;
            held[k] = 1'b0; held_s[k] = '0; took[k] = 1'b0; sent[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(ov[0]), 0);
        chk("reset_sum", 32'(s[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(rdy[0]), 1);

        op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            vin[0] = (c < 8); a[0] = 16'(c * 16'h1111); b[0] = 16'h0F0F; cin[0] = c[0];
            @(negedge clk);
            if (ov[0]) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("stream_count", 32'(cnt), 8);
        chk("stream_span", 32'(last - first), 7);
        chk("stream_first", 32'(first), 2);

        sent1 = 0;
        for (int c = 0; c < 40 && (sent1 < 8 || q0.size() > 0); c++) begin
            @(posedge clk); #1;
            vin[0] = (sent1 < 8);
            a[0] = 16'($urandom); b[0] = 16'($urandom); cin[0] = 1'($urandom_range(1));
            ordy[0] = !(c >= 3 && c < 7);
            @(negedge clk);
            if (c == 6) chk("bp_ready_low", 32'(rdy[0]), 0);
            if (vin[0] && rdy[0]) sent1++;
        end
        chk("bp_sent", 32'(sent1), 8);
        chk("bp_drained", 32'(q0.size()), 0);

        for (int c = 0; c < 60000; c++) begin
            if (sent[0] >= N_RAND && sent[1] >= N_RAND && q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (!vin[k] || took[k]) begin
                    vin[k] = (sent[k] < N_RAND) && ($urandom_range(3) != 0);
                    a[k] = 16'($urandom); b[k] = 16'($urandom); cin[k] = 1'($urandom_range(1));
                end
                ordy[k] = ($urandom_range(3) != 0);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                took[k] = vin[k] && rdy[k];
                if (took[k]) sent[k]++;
            end
        end
        chk("rand_sent16", 32'(sent[0]), N_RAND);
        chk("rand_sent13", 32'(sent[1]), N_RAND);
        chk("rand_drain16", 32'(q0.size()), 0);
        chk("rand_drain13", 32'(q1.size()), 0);

        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b1; ordy[k] = 1'b0;
            a[k] = 16'($urandom); b[k] = 16'($urandom); cin[k] = 1'b1;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vin[0] = 1'b0; vin[1] = 1'b0;
        @(negedge clk);
        chk("full_valid", 32'(ov[0]), 1);
        chk("full_ready", 32'(rdy[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid16", 32'(ov[0]), 0);
        chk("midrst_sum16", 32'(s[0]), 0);
        chk("midrst_valid13", 32'(ov[1]), 0);
        chk("midrst_sum13", 32'(s[1]), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1; ordy[0] = 1'b1; ordy[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_valid16", 32'(ov[0]), 0);
            chk("post_rst_valid13", 32'(ov[1]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
